// File: rtl/conv_encoder_pkg.sv
// Shared constants and FSM state type for the rate-1/2, K=3 convolutional encoder
// and the Viterbi decoder model that reuses its core.
package conv_encoder_pkg;

   localparam int          K      = 3;
   localparam logic [2:0]  G0_DEF = 3'b111;
   localparam logic [2:0]  G1_DEF = 3'b101;

   typedef enum logic [1:0] {
      ST_DATA  = 2'd0,
      ST_TAIL0 = 2'd1,
      ST_TAIL1 = 2'd2
   } enc_state_t;

endpackage

// File: rtl/conv_encoder_if.sv
// Stream interface of the convolutional encoder: bit input channel, coded-pair
// output channel and the per-frame pair counter.
interface conv_encoder_if #(
   parameter int CNT_W = 16
) ();

   // Both channels: a beat transfers on a rising edge where valid && ready; the
   // source keeps valid and payload stable until then, and ready may depend on valid.
   logic             in_valid;
   logic             in_ready;
   logic             in_bit;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_pair;
   logic             out_last;
   logic [CNT_W-1:0] pair_count;

   modport master (
      output in_valid, in_bit, in_last, out_ready,
      input  in_ready, out_valid, out_pair, out_last, pair_count
   );

   modport slave (
      input  in_valid, in_bit, in_last, out_ready,
      output in_ready, out_valid, out_pair, out_last, pair_count
   );

endinterface

// File: rtl/conv_enc_core.sv
// Combinational encoder step: {b, s1, s0} -> coded pair and next shift state.
// Kept free of registers so the decoder's reference model can instantiate it.
module conv_enc_core
   import conv_encoder_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEF,
   parameter logic [K-1:0] G1 = G1_DEF
) (
   input  logic         i_bit,
   input  logic [K-2:0] i_state,
   output logic [1:0]   o_pair,
   output logic [K-2:0] o_state_nxt
);

   logic [K-1:0] w_taps;

   assign w_taps      = {i_bit, i_state};
   assign o_pair      = {^(G0 & w_taps), ^(G1 & w_taps)};
   assign o_state_nxt = w_taps[K-1:1];

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder with registered output and per-frame pair count.
// Define CONV_ENCODER_TAIL_EN to append two zero-flush pairs after each frame.
module conv_encoder
   import conv_encoder_pkg::*;
#(
   parameter logic [2:0] G0    = G0_DEF,
   parameter logic [2:0] G1    = G1_DEF,
   parameter int         CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              renew,
   conv_encoder_if.slave     bus,
   output enc_state_t        o_dbg_state
);

   enc_state_t       r_state, w_state_nxt;
   logic [1:0]       r_sreg;
   logic             r_out_valid;
   logic [1:0]       r_out_pair;
   logic             r_out_last;
   logic [CNT_W-1:0] r_pair_cnt;
   logic             r_cnt_clr;

   logic             w_flush;
   logic             w_out_free;
   logic             w_in_xfer;
   logic             w_hs;
   logic             w_enc_bit;
   logic             w_load;
   logic             w_load_last;
   logic             w_clr_sreg;
   logic [1:0]       w_pair;
   logic [1:0]       w_sreg_nxt;

   assign w_flush      = rst | renew;
   assign w_out_free   = !r_out_valid || bus.out_ready;
   assign bus.in_ready = !w_flush && (r_state == ST_DATA) && w_out_free;
   assign w_in_xfer    = bus.in_valid && bus.in_ready;
   assign w_hs         = r_out_valid && bus.out_ready;
   // Tail pairs encode a zero so the shift state drains to 00.
   assign w_enc_bit    = (r_state == ST_DATA) ? bus.in_bit : 1'b0;

   conv_enc_core #(.G0(G0), .G1(G1)) u_core (
      .i_bit       (w_enc_bit),
      .i_state     (r_sreg),
      .o_pair      (w_pair),
      .o_state_nxt (w_sreg_nxt)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_last = 1'b0;
      w_clr_sreg  = 1'b0;
      case (r_state)
         ST_DATA: begin
            if (w_in_xfer) begin
               w_load = 1'b1;
               if (bus.in_last) begin
`ifdef CONV_ENCODER_TAIL_EN
                  w_state_nxt = ST_TAIL0;
`else
                  w_load_last = 1'b1;
                  w_clr_sreg  = 1'b1;
`endif
               end
            end
         end
`ifdef CONV_ENCODER_TAIL_EN
         ST_TAIL0: begin
            if (w_out_free) begin
               w_load      = 1'b1;
               w_state_nxt = ST_TAIL1;
            end
         end
         ST_TAIL1: begin
            if (w_out_free) begin
               w_load      = 1'b1;
               w_load_last = 1'b1;
               w_state_nxt = ST_DATA;
            end
         end
`endif
         default: w_state_nxt = ST_DATA;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_state     <= ST_DATA;
         r_sreg      <= 2'b00;
         r_out_valid <= 1'b0;
         r_out_pair  <= 2'b00;
         r_out_last  <= 1'b0;
         r_pair_cnt  <= '0;
         r_cnt_clr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_sreg      <= w_clr_sreg ? 2'b00 : w_sreg_nxt;
            r_out_valid <= 1'b1;
            r_out_pair  <= w_pair;
            r_out_last  <= w_load_last;
         end else if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
         // The count of a finished frame stays visible for one cycle, then restarts.
         if (r_cnt_clr)
            r_pair_cnt <= w_hs ? CNT_W'(1) : '0;
         else if (w_hs)
            r_pair_cnt <= r_pair_cnt + CNT_W'(1);
         r_cnt_clr <= w_hs && r_out_last;
      end
   end

   assign bus.out_valid  = r_out_valid;
   assign bus.out_pair   = r_out_pair;
   assign bus.out_last   = r_out_last;
   assign bus.pair_count = r_pair_cnt;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: known-answer frames, stalls, renew abort,
// random traffic against a sequence-level model, and back-to-back frames.
module tb_conv_encoder;
   import conv_encoder_pkg::*;

   localparam int         CNT_W  = 16;
   localparam logic [2:0] REF_G0 = 3'b111;
   localparam logic [2:0] REF_G1 = 3'b101;
`ifdef CONV_ENCODER_TAIL_EN
   localparam bit TAIL_EN = 1'b1;
`else
   localparam bit TAIL_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       renew;
   enc_state_t dbg_state;

   conv_encoder_if #(.CNT_W(CNT_W)) bus ();

   conv_encoder #(.G0(REF_G0), .G1(REF_G1), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .renew       (renew),
      .bus         (bus.slave),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   logic [2:0] exp_q[$];
   logic [2:0] obs_q[$];
   int         obs_t_q[$];
   bit         cur_frame[$];
   int         rdy_mode = 0;
   int         cyc = 0;
   int         stall_viol = 0;
   bit         prev_stall = 1'b0;
   logic [2:0] prev_out;
   int         last_cnt = -1;
   int         after_cnt = -1;
   bit         pend1 = 1'b0;
   bit         pend2 = 1'b0;

   // out_ready driver: 0 = always ready, 1 = toggling, 2 = random
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1:       bus.out_ready = ~bus.out_ready;
            2:       bus.out_ready = ($urandom_range(0, 2) != 0);
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: records accepted pairs, stall stability and the frame-end counter values.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (pend2) begin
            after_cnt = int'(bus.pair_count);
            pend2 = 1'b0;
         end
         if (pend1) begin
            last_cnt = int'(bus.pair_count);
            pend1 = 1'b0;
            pend2 = 1'b1;
         end
         if (prev_stall && (!bus.out_valid || {bus.out_last, bus.out_pair} !== prev_out))
            stall_viol++;
         prev_stall = bus.out_valid && !bus.out_ready && !rst && !renew;
         prev_out   = {bus.out_last, bus.out_pair};
         if (bus.out_valid && bus.out_ready && !rst && !renew) begin
            obs_q.push_back({bus.out_last, bus.out_pair});
            obs_t_q.push_back(cyc);
            if (bus.out_last) pend1 = 1'b1;
         end
      end
   end

   // Reference model: the frame as a bit sequence, each pair a dot product of the
   // generator with the last three sequence bits (zeros before the frame start).
   function automatic void model_frame(input bit term);
      bit seq[$];
      bit b0, b1, b2, p1, p0;
      seq = cur_frame;
      if (term && TAIL_EN) begin
         seq.push_back(1'b0);
         seq.push_back(1'b0);
      end
      for (int k = 0; k < seq.size(); k++) begin
         b0 = seq[k];
         b1 = (k >= 1) ? seq[k-1] : 1'b0;
         b2 = (k >= 2) ? seq[k-2] : 1'b0;
         p1 = (REF_G0[2] & b0) ^ (REF_G0[1] & b1) ^ (REF_G0[0] & b2);
         p0 = (REF_G1[2] & b0) ^ (REF_G1[1] & b1) ^ (REF_G1[0] & b2);
         exp_q.push_back({term && (k == seq.size() - 1), p1, p0});
      end
   endfunction

   task automatic send_frame(input bit term, input bit gaps, output bit ok);
      int  i = 0;
      int  guard = 0;
      bit  xfer;
      ok = 1'b1;
      while (i < cur_frame.size()) begin
         guard++;
         if (guard > 500) begin
            ok = 1'b0;
            break;
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            continue;
         end
         bus.in_valid = 1'b1;
         bus.in_bit   = cur_frame[i];
         bus.in_last  = term && (i == cur_frame.size() - 1);
         @(negedge clk);
         xfer = bus.in_ready;
         @(posedge clk);
         #1;
         if (xfer) i++;
      end
   endtask

   task automatic wait_pairs(input int n, output bit ok);
      int g = 0;
      while (obs_q.size() < n && g < 400) begin
         @(posedge clk);
         #1;
         g++;
      end
      ok = (obs_q.size() >= n);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      renew = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_bit = 1'b1;
      bus.in_last = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_pair !== 2'b00) begin errors++; $display("FAIL reset_out_pair: got %b want 00", bus.out_pair); end
      checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
      checks++; if (bus.pair_count !== '0) begin errors++; $display("FAIL reset_pair_count: got %0d want 0", bus.pair_count); end
      checks++; if (dbg_state !== ST_DATA) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_DATA); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_frame_basic();
      logic [2:0] ka[$];
      bit ok;
`ifdef CONV_ENCODER_TAIL_EN
      ka = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
`else
      ka = '{3'b011, 3'b010, 3'b000, 3'b101};
`endif
      rdy_mode = 0;
      obs_q.delete();
      last_cnt = -1;
      after_cnt = -1;
      cur_frame = '{1'b1, 1'b0, 1'b1, 1'b1};
      send_frame(1'b1, 1'b0, ok);
      bus.in_valid = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL basic_send: timeout got 0 want 1"); end
      wait_pairs(ka.size(), ok);
      checks++; if (obs_q.size() != ka.size()) begin errors++; $display("FAIL basic_count: got %0d pairs want %0d", obs_q.size(), ka.size()); end
      for (int i = 0; i < ka.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== ka[i]) begin errors++; $display("FAIL basic_pair[%0d]: got %b want %b", i, obs_q[i], ka[i]); end
      end
      checks++; if (last_cnt != ka.size()) begin errors++; $display("FAIL basic_pair_count_end: got %0d want %0d", last_cnt, ka.size()); end
      checks++; if (after_cnt != 0) begin errors++; $display("FAIL basic_pair_count_clear: got %0d want 0", after_cnt); end
   endtask

   task automatic test_stall();
      bit ok;
      rdy_mode = 1;
      stall_viol = 0;
      obs_q.delete();
      exp_q.delete();
      cur_frame = '{1'b1, 1'b0, 1'b1, 1'b1};
      model_frame(1'b1);
      send_frame(1'b1, 1'b0, ok);
      bus.in_valid = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL stall_send: timeout got 0 want 1"); end
      wait_pairs(exp_q.size(), ok);
      rdy_mode = 0;
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d pairs want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_pair[%0d]: got %b want %b", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stability: got %0d changes want 0", stall_viol); end
   endtask

   task automatic test_single_bit();
      logic [2:0] ka[$];
      bit ok;
      logic r0, r1;
`ifdef CONV_ENCODER_TAIL_EN
      ka = '{3'b000, 3'b000, 3'b100};
`else
      ka = '{3'b100};
`endif
      rdy_mode = 0;
      obs_q.delete();
      cur_frame = '{1'b0};
      send_frame(1'b1, 1'b0, ok);
      bus.in_valid = 1'b0;
      @(negedge clk);
      r0 = bus.in_ready;
      @(negedge clk);
      r1 = bus.in_ready;
      checks++; if (!ok) begin errors++; $display("FAIL single_send: timeout got 0 want 1"); end
      checks++; if (r0 !== !TAIL_EN) begin errors++; $display("FAIL single_ready_tail0: got %b want %b", r0, !TAIL_EN); end
      checks++; if (r1 !== !TAIL_EN) begin errors++; $display("FAIL single_ready_tail1: got %b want %b", r1, !TAIL_EN); end
      wait_pairs(ka.size(), ok);
      checks++; if (obs_q.size() != ka.size()) begin errors++; $display("FAIL single_count: got %0d pairs want %0d", obs_q.size(), ka.size()); end
      for (int i = 0; i < ka.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== ka[i]) begin errors++; $display("FAIL single_pair[%0d]: got %b want %b", i, obs_q[i], ka[i]); end
      end
   endtask

   task automatic test_renew();
      logic [2:0] ka[$];
      bit ok;
`ifdef CONV_ENCODER_TAIL_EN
      ka = '{3'b011, 3'b010, 3'b111};
`else
      ka = '{3'b111};
`endif
      rdy_mode = 0;
      obs_q.delete();
      exp_q.delete();
      cur_frame = '{1'b1, 1'b1, 1'b0};
      model_frame(1'b0);
      send_frame(1'b0, 1'b0, ok);
      bus.in_valid = 1'b0;
      renew = 1'b1;
      @(posedge clk);
      #1;
      renew = 1'b0;
      @(negedge clk);
      checks++; if (!ok) begin errors++; $display("FAIL renew_send: timeout got 0 want 1"); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL renew_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.pair_count !== '0) begin errors++; $display("FAIL renew_pair_count: got %0d want 0", bus.pair_count); end
      checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL renew_pre_count: got %0d pairs want 2", obs_q.size()); end
      for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL renew_pre_pair[%0d]: got %b want %b", i, obs_q[i], exp_q[i]); end
      end
      @(posedge clk);
      #1;
      obs_q.delete();
      cur_frame = '{1'b1};
      send_frame(1'b1, 1'b0, ok);
      bus.in_valid = 1'b0;
      wait_pairs(ka.size(), ok);
      checks++; if (obs_q.size() != ka.size()) begin errors++; $display("FAIL renew_next_count: got %0d pairs want %0d", obs_q.size(), ka.size()); end
      for (int i = 0; i < ka.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== ka[i]) begin errors++; $display("FAIL renew_next_pair[%0d]: got %b want %b", i, obs_q[i], ka[i]); end
      end
   endtask

   task automatic test_random();
      bit ok;
      bit all_ok = 1'b1;
      rdy_mode = 2;
      stall_viol = 0;
      obs_q.delete();
      exp_q.delete();
      for (int f = 0; f < 8; f++) begin
         cur_frame.delete();
         for (int j = 0; j < $urandom_range(1, 9); j++) cur_frame.push_back(1'($urandom_range(0, 1)));
         model_frame(1'b1);
         send_frame(1'b1, 1'b1, ok);
         if (!ok) all_ok = 1'b0;
      end
      bus.in_valid = 1'b0;
      wait_pairs(exp_q.size(), ok);
      rdy_mode = 0;
      checks++; if (!all_ok) begin errors++; $display("FAIL random_send: timeout got 0 want 1"); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d pairs want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_pair[%0d]: got %b want %b", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL random_stability: got %0d changes want 0", stall_viol); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit all_ok = 1'b1;
      bit all_bits[$];
      int lens[$];
      int base = 0;
      int span;
      rdy_mode = 0;
      obs_q.delete();
      obs_t_q.delete();
      exp_q.delete();
      for (int f = 0; f < 5; f++) begin
         cur_frame.delete();
         for (int j = 0; j < $urandom_range(1, 7); j++) cur_frame.push_back(1'($urandom_range(0, 1)));
         lens.push_back(cur_frame.size());
         foreach (cur_frame[j]) all_bits.push_back(cur_frame[j]);
         model_frame(1'b1);
         send_frame(1'b1, 1'b0, ok);
         if (!ok) all_ok = 1'b0;
      end
      bus.in_valid = 1'b0;
      wait_pairs(exp_q.size(), ok);
      checks++; if (!all_ok) begin errors++; $display("FAIL b2b_send: timeout got 0 want 1"); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d pairs want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_pair[%0d]: got %b want %b", i, obs_q[i], exp_q[i]); end
      end
      span = (obs_t_q.size() > 0) ? obs_t_q[obs_t_q.size()-1] - obs_t_q[0] : -1;
      checks++; if (span != exp_q.size() - 1) begin errors++; $display("FAIL b2b_no_idle: got span %0d want %0d", span, exp_q.size() - 1); end
      // With G1=101 the lower pair bit is b[k]^b[k-2], so each frame inverts directly.
      for (int f = 0, bi = 0; f < lens.size(); f++) begin
         int  n = lens[f] + (TAIL_EN ? 2 : 0);
         bit  dec[$];
         int  bad = 0;
         for (int k = 0; k < n; k++) begin
            bit p0 = (base + k < obs_q.size()) ? obs_q[base + k][0] : 1'b0;
            bit d  = p0 ^ ((k >= 2) ? dec[k-2] : 1'b0);
            bit want = (k < lens[f]) ? all_bits[bi + k] : 1'b0;
            dec.push_back(d);
            if (d !== want) bad++;
         end
         checks++; if (bad != 0) begin errors++; $display("FAIL b2b_decode[%0d]: got %0d wrong bits want 0", f, bad); end
         base += n;
         bi += lens[f];
      end
   endtask

   initial begin
      rst = 1'b1;
      renew = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_bit = 1'b0;
      bus.in_last = 1'b0;
      test_reset();
      test_frame_basic();
      test_stall();
      test_single_bit();
      test_renew();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter G0, default 3'b111, generator for out_pair[1]; bit 2 taps the current input bit, bit 1 the newest state bit, bit 0 the oldest state bit.
REQ-002 SHALL have parameter G1, default 3'b101, generator for out_pair[0], with the same tap order as G0.
REQ-003 SHALL have parameter CNT_W, default 16, width of pair_count.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port renew  input  1  synchronous frame abort, active-high.
REQ-007 SHALL have port in_valid  input  1  in_bit and in_last are valid.
REQ-008 SHALL have port in_ready  output  1  encoder accepts an input bit this cycle.
REQ-009 SHALL have port in_bit  input  1  information bit.
REQ-010 SHALL have port in_last  input  1  marks the final data bit of the frame.
REQ-011 SHALL have port out_valid  output  1  out_pair holds a valid coded pair.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_pair.
REQ-013 SHALL have port out_pair  output  2  coded pair; [1]=G0 output, [0]=G1 output.
REQ-014 SHALL have port out_last  output  1  marks the final pair of the frame.
REQ-015 SHALL have port pair_count  output  CNT_W  number of pairs accepted downstream in the current frame.

Function
REQ-016 SHALL hold a 2-bit state {s1,s0}, where s1 is the newest bit; a transfer shifts in_bit into s1 and s1 into s0.
REQ-017 SHALL compute out_pair[1] as the XOR-reduction of G0 AND {b,s1,s0}, and out_pair[0] likewise with G1, where b is the encoded bit.
REQ-018 SHALL register the output: the pair appears on out_pair/out_valid in the cycle after the input transfer (1-cycle latency).
REQ-019 SHALL drive in_ready = (state==DATA) && (!out_valid || out_ready), which gives full throughput with no bubbles.
REQ-020 SHALL hold out_pair, out_valid and out_last stable while out_valid=1 and out_ready=0.
REQ-021 SHALL implement FSM states DATA, TAIL0 and TAIL1; reset enters DATA.
REQ-022 SHALL go DATA->TAIL0 on the transfer of an input with in_last=1 (tail build only).
REQ-023 SHALL emit the TAIL0 and TAIL1 pairs by encoding b=0, each when the output register is free.
REQ-024 SHALL go TAIL0->TAIL1 and TAIL1->DATA on loading each tail pair.
REQ-025 SHALL hold in_ready=0 in the TAIL states.
REQ-026 SHALL assert out_last only on the TAIL1 pair (tail build), leaving state {s1,s0}=00 at frame end.
REQ-027 SHALL increment pair_count on each out_valid&&out_ready handshake, wrapping modulo 2^CNT_W.
REQ-028 SHALL clear pair_count on the cycle after the out_last handshake.
REQ-029 SHALL treat renew=1 identically to rst in the same cycle, dropping any pending pair; renew has priority over any simultaneous handshake.
REQ-030 SHALL accept in_last=1 on the first bit of a frame (single-bit frame) as a legal input.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, set: state DATA, {s1,s0}=00, out_valid=0, out_pair=00, out_last=0, pair_count=0.
REQ-032 SHALL, on reset asserted mid-frame or mid-tail, abort the frame with no further pairs emitted.
REQ-033 SHALL drive in_ready=0 during the cycle rst=1 and drive it from REQ-019 thereafter.

Configuration
REQ-034 SHALL use macro CONV_ENCODER_TAIL_EN; when defined, the tail behaviour is as above (2 zero-flush pairs per frame).
REQ-035 SHALL, when CONV_ENCODER_TAIL_EN is undefined, omit the TAIL states; out_last then accompanies the pair of the in_last bit and {s1,s0} clears to 00 after that transfer.

Structure
REQ-036 SHALL place in the shared viterbi package: the constants K=3, G0_DEF=3'b111, G1_DEF=3'b101, and the FSM state enum typedef.
REQ-037 SHALL contain one sub-module, conv_enc_core: combinational {b,s1,s0} -> out_pair and next state, reusable by the decoder's model.

Verification
REQ-038 SHALL verify the frame 1,0,1,1 (last on the 4th bit), out_ready=1 -> pairs 11,10,00,01,01,11, out_last on the 6th pair, pair_count reaches 6, then resets to 0.
REQ-039 SHALL verify the same frame with out_ready toggling 1,0 -> identical pair sequence, outputs stable while stalled, no drops or duplicates.
REQ-040 SHALL verify a single-bit frame with bit 0 and last -> pairs 00,00,00, out_last on the 3rd pair; in_ready=0 during the two tail cycles.
REQ-041 SHALL verify renew asserted after the 2nd pair of a frame -> out_valid=0 next cycle, the next frame 1 (last) yields 11,10,11.
REQ-042 SHALL verify an undefined CONV_ENCODER_TAIL_EN with the frame 1,0,1,1 -> pairs 11,10,00,01, out_last on 01, the next frame starts from state 00.
REQ-043 SHALL verify back-to-back frames with in_valid held high -> no idle cycle on out_valid except during tail insertion; pairs are decodable by the team's Viterbi decoder to the original bits.
